// File: rtl/uart_pkg.sv
// Shared types and helpers for the debug-transport UART path (RX framer, TX side).
// Opcode and frame-state enums, sync marker default, timeout sizing function.
package uart_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_RD_REG  = 3'd1,
        OP_WR_REG  = 3'd2,
        OP_RESUME  = 3'd3,
        OP_WR_MEM  = 3'd4,
        OP_RD_MEM  = 3'd5,
        OP_EXEC    = 3'd6,
        OP_WR_CSR  = 3'd7
    } cmd_op_t;

    typedef enum logic [1:0] {
        st_sync = 2'd0,
        st_cmd  = 2'd1,
        st_data = 2'd2,
        st_out  = 2'd3
    } frame_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h01;

    // One byte time is 10 bit times (start + 8 data + stop).
    function automatic int unsigned timeout_cycles(input int unsigned clk_rate,
                                                   input int unsigned baud_rate,
                                                   input int unsigned bytes);
        return (clk_rate / baud_rate) * 10 * bytes;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Loadable inter-byte timeout counter. Saturates at LIMIT_I-1 so it never wraps;
// EXPIRED_O is high while enabled, not cleared, and sitting at that terminal count.
module uart_byte_timer #(
    parameter int W = 16
) (
    input  logic         CLK_I,
    input  logic         RST_NI,
    input  logic         CLEAR_I,
    input  logic         ENABLE_I,
    input  logic [W-1:0] LIMIT_I,
    output logic         EXPIRED_O
);

    logic [W-1:0] count_q;
    logic         at_limit;

    assign at_limit  = (count_q == (LIMIT_I - 1'b1));
    assign EXPIRED_O = ENABLE_I && !CLEAR_I && at_limit;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            count_q <= '0;
        end else if (CLEAR_I) begin
            count_q <= '0;
        end else if (ENABLE_I && !at_limit) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// Assembles UART bytes into sync/command/payload frames and presents them on a
// valid/ready command port, with sticky timeout and overrun error flags.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE      = 100*10**6,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic        RX_DONE_I,
    input  logic [7:0]  RX_DATA_I,
    output logic        CMD_VALID_O,
    input  logic        CMD_READY_I,
    output logic [2:0]  CMD_OP_O,
    output logic [4:0]  CMD_ADDR_O,
    output logic [31:0] CMD_DATA_O,
    output logic        ERR_TIMEOUT_O,
    output logic        ERR_OVERRUN_O,
    input  logic        ERR_CLR_I,
    output logic        BUSY_O,
    output logic [1:0]  DBG_STATE_O
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_RATE, BAUD_RATE, TIMEOUT_BYTES);
    localparam int          TW             = $clog2(TIMEOUT_CYCLES) + 1;

    frame_state_t state_q, state_d;
    cmd_op_t      op_q, op_d;
    logic [4:0]   addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic [1:0]   n_q, n_d;
    logic         valid_q, busy_q, err_to_q, err_ov_q;
    logic         set_to, set_ov;
    logic         in_frame, expired;

    assign in_frame = (state_q == st_cmd) || (state_q == st_data);

    uart_byte_timer #(.W(TW)) u_timer (
        .CLK_I     (CLK_I),
        .RST_NI    (RST_NI),
        .CLEAR_I   (RX_DONE_I || !in_frame),
        .ENABLE_I  (in_frame),
        .LIMIT_I   (TW'(TIMEOUT_CYCLES)),
        .EXPIRED_O (expired)
    );

    // Handshake: CMD_VALID_O rises with a complete frame and holds it stable until
    // a cycle with CMD_VALID_O && CMD_READY_I; valid is never withdrawn otherwise.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        n_d     = n_q;
        set_to  = 1'b0;
        set_ov  = 1'b0;
        case (state_q)
            st_sync: begin
                if (RX_DONE_I && RX_DATA_I == SYNC_BYTE) state_d = st_cmd;
            end
            st_cmd: begin
                if (RX_DONE_I) begin
                    op_d   = cmd_op_t'(RX_DATA_I[7:5]);
                    addr_d = RX_DATA_I[4:0];
                    data_d = '0;
                    n_d    = '0;
                    state_d = RX_DATA_I[7] ? st_data : st_out;
                end else if (expired) begin
                    state_d = st_sync;
                    set_to  = 1'b1;
                end
            end
            st_data: begin
                if (RX_DONE_I) begin
                    data_d[8*n_q +: 8] = RX_DATA_I;
                    n_d = n_q + 2'd1;
                    if (n_q == 2'd3) state_d = st_out;
                end else if (expired) begin
                    state_d = st_sync;
                    set_to  = 1'b1;
                end
            end
            st_out: begin
                // A byte arriving with the handshake is judged as if already in st_sync.
                if (CMD_READY_I) begin
                    state_d = (RX_DONE_I && RX_DATA_I == SYNC_BYTE) ? st_cmd : st_sync;
                end else if (RX_DONE_I) begin
                    set_ov = 1'b1;
                end
            end
            default: state_d = st_sync;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q  <= st_sync;
            op_q     <= OP_NOP;
            addr_q   <= '0;
            data_q   <= '0;
            n_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            n_q      <= n_d;
            valid_q  <= (state_d == st_out);
            busy_q   <= (state_d != st_sync);
            err_to_q <= set_to || (err_to_q && !ERR_CLR_I);
            err_ov_q <= set_ov || (err_ov_q && !ERR_CLR_I);
        end
    end

    assign CMD_VALID_O   = valid_q;
    assign CMD_OP_O      = op_q;
    assign CMD_ADDR_O    = addr_q;
    assign CMD_DATA_O    = data_q;
    assign ERR_TIMEOUT_O = err_to_q;
    assign ERR_OVERRUN_O = err_ov_q;
    assign BUSY_O        = busy_q;
    assign DBG_STATE_O   = state_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: frame decode, sync hunting, timeout, overrun,
// simultaneous-event priorities and asynchronous reset.
module tb_uart_rx_framer;
    import uart_pkg::*;

    // Small clock/baud ratio: (1_000_000/100_000)*10*4 = 400 cycles of timeout.
    localparam int unsigned TO_CYC = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        cmd_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        cmd_valid, err_to, err_ov, busy;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  dbg_state;

    int passed = 0;
    int total  = 0;

    uart_rx_framer #(
        .CLK_RATE      (1_000_000),
        .BAUD_RATE     (100_000),
        .TIMEOUT_BYTES (4),
        .SYNC_BYTE     (8'h01)
    ) dut (
        .CLK_I         (clk),
        .RST_NI        (rst_n),
        .RX_DONE_I     (rx_done),
        .RX_DATA_I     (rx_data),
        .CMD_VALID_O   (cmd_valid),
        .CMD_READY_I   (cmd_ready),
        .CMD_OP_O      (cmd_op),
        .CMD_ADDR_O    (cmd_addr),
        .CMD_DATA_O    (cmd_data),
        .ERR_TIMEOUT_O (err_to),
        .ERR_OVERRUN_O (err_ov),
        .ERR_CLR_I     (err_clr),
        .BUSY_O        (busy),
        .DBG_STATE_O   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; the byte is sampled on the next posedge, returns at the negedge after.
    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic ready_pulse();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_addr", {24'd0, cmd_op, cmd_addr}, 32'd0);
        check("rst_data", cmd_data, 32'd0);
        check("rst_errs", {30'd0, err_to, err_ov}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame without payload: 01 2A
        send_byte(8'h01);
        check("t1_busy_cmd", {31'd0, busy}, 32'd1);
        check("t1_valid_pre", {31'd0, cmd_valid}, 32'd0);
        send_byte(8'h2A);
        check("t1_valid", {31'd0, cmd_valid}, 32'd1);
        check("t1_op", {29'd0, cmd_op}, 32'd1);
        check("t1_addr", {27'd0, cmd_addr}, 32'h0A);
        check("t1_data", cmd_data, 32'd0);
        @(negedge clk);
        check("t1_valid_hold", {31'd0, cmd_valid}, 32'd1);
        ready_pulse();
        check("t1_valid_after", {31'd0, cmd_valid}, 32'd0);
        check("t1_busy_after", {31'd0, busy}, 32'd0);

        // Frame with payload: 01 85 78 56 34 12
        send_byte(8'h01);
        send_byte(8'h85);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        check("t2_valid_early", {31'd0, cmd_valid}, 32'd0);
        send_byte(8'h12);
        check("t2_valid", {31'd0, cmd_valid}, 32'd1);
        check("t2_op", {29'd0, cmd_op}, 32'd4);
        check("t2_addr", {27'd0, cmd_addr}, 32'd5);
        check("t2_data", cmd_data, 32'h12345678);
        ready_pulse();

        // Leading garbage byte is ignored
        send_byte(8'h55);
        check("t3_busy_garbage", {31'd0, busy}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h20);
        check("t3_valid", {31'd0, cmd_valid}, 32'd1);
        check("t3_op_addr", {24'd0, cmd_op, cmd_addr}, {24'd0, 3'd1, 5'd0});
        check("t3_errs", {30'd0, err_to, err_ov}, 32'd0);
        ready_pulse();

        // Inter-byte timeout mid-payload
        send_byte(8'h01);
        send_byte(8'h85);
        send_byte(8'h11);
        repeat (TO_CYC - 1) @(negedge clk);
        check("t4_busy_before_to", {31'd0, busy}, 32'd1);
        check("t4_err_before_to", {31'd0, err_to}, 32'd0);
        @(negedge clk);
        check("t4_busy_after_to", {31'd0, busy}, 32'd0);
        check("t4_err_to", {31'd0, err_to}, 32'd1);
        send_byte(8'h01);
        send_byte(8'h2A);
        check("t4_clean_op_addr", {24'd0, cmd_op, cmd_addr}, {24'd0, 3'd1, 5'h0A});
        check("t4_clean_valid", {31'd0, cmd_valid}, 32'd1);
        check("t4_err_sticky", {31'd0, err_to}, 32'd1);
        ready_pulse();
        clr_pulse();
        check("t4_err_cleared", {31'd0, err_to}, 32'd0);

        // Byte arriving in the expiry cycle wins over the timeout
        send_byte(8'h01);
        repeat (TO_CYC - 1) @(negedge clk);
        send_byte(8'h2A);
        check("t5_valid", {31'd0, cmd_valid}, 32'd1);
        check("t5_no_to", {31'd0, err_to}, 32'd0);
        ready_pulse();

        // Overrun while stalled
        send_byte(8'h01);
        send_byte(8'h85);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h01);
        check("t6_err_ov", {31'd0, err_ov}, 32'd1);
        check("t6_valid_held", {31'd0, cmd_valid}, 32'd1);
        check("t6_data_held", cmd_data, 32'h12345678);
        check("t6_op_held", {29'd0, cmd_op}, 32'd4);
        clr_pulse();
        check("t6_ov_cleared", {31'd0, err_ov}, 32'd0);
        err_clr = 1'b1;
        send_byte(8'h33);
        err_clr = 1'b0;
        check("t6_set_beats_clr", {31'd0, err_ov}, 32'd1);
        clr_pulse();
        // Sync byte together with the handshake goes straight to st_cmd
        cmd_ready = 1'b1;
        send_byte(8'h01);
        cmd_ready = 1'b0;
        check("t6_sim_no_ov", {31'd0, err_ov}, 32'd0);
        check("t6_sim_valid", {31'd0, cmd_valid}, 32'd0);
        check("t6_sim_busy", {31'd0, busy}, 32'd1);
        check("t6_sim_state", {30'd0, dbg_state}, {30'd0, st_cmd});
        send_byte(8'h2A);
        check("t6_next_frame", {23'd0, cmd_valid, cmd_op, cmd_addr}, {23'd0, 1'b1, 3'd1, 5'h0A});
        ready_pulse();

        // Asynchronous reset mid-payload
        send_byte(8'h01);
        send_byte(8'h85);
        send_byte(8'h78);
        check("t7_pre_rst_op", {29'd0, cmd_op}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_busy", {31'd0, busy}, 32'd0);
        check("t7_rst_op_addr", {24'd0, cmd_op, cmd_addr}, 32'd0);
        check("t7_rst_data", cmd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h85);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        check("t7_post_valid", {31'd0, cmd_valid}, 32'd1);
        check("t7_post_data", cmd_data, 32'hDEADBEEF);
        ready_pulse();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
